writeback_buffer: RTL and testbench

Queues dirty blocks evicted by the set-associative cache and drains them to main memory one word at a time, so eviction never stalls on memory latency. It sits directly downstream of the cache's replacement path (dirty victim → this block → memory write port). It also answers a combinational probe so that a miss fill can take data from a queued victim instead of stale memory. It coalesces repeat evictions of the same block that have not started draining.

---
 rtl/writeback_buffer_if.sv | 33 +++
 rtl/writeback_buffer.sv | 159 +++++++++++++++
 tb/tb_writeback_buffer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_buffer_if.sv
// Eviction, probe and memory-write signals of the writeback buffer.
// The buffer connects through the slave modport; the cache/memory side uses master.
interface writeback_buffer_if #(
    parameter int unsigned BLOCK_ADDR_W = 8,
    parameter int unsigned BLOCK_SIZE   = 16,
    parameter int unsigned WORD_W       = 32
);
    localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
    localparam int unsigned BLK_W = BLOCK_SIZE * WORD_W;

    logic                      evict_valid;
    logic                      evict_ready;
    logic [BLOCK_ADDR_W-1:0]   evict_addr;
    logic [BLK_W-1:0]          evict_data;
    logic [BLOCK_ADDR_W-1:0]   probe_addr;
    logic                      probe_hit;
    logic [BLK_W-1:0]          probe_data;
    logic                      mem_wvalid;
    logic                      mem_wready;
    logic [BLOCK_ADDR_W+OFF_W-1:0] mem_waddr;
    logic [WORD_W-1:0]         mem_wdata;
    logic                      mem_wlast;

    modport slave (
        input  evict_valid, evict_addr, evict_data, probe_addr, mem_wready,
        output evict_ready, probe_hit, probe_data, mem_wvalid, mem_waddr, mem_wdata, mem_wlast
    );

    modport master (
        output evict_valid, evict_addr, evict_data, probe_addr, mem_wready,
        input  evict_ready, probe_hit, probe_data, mem_wvalid, mem_waddr, mem_wdata, mem_wlast
    );
endinterface

// File: rtl/writeback_buffer.sv
// Circular queue of dirty evicted blocks drained word-by-word to memory,
// with same-address coalescing and a combinational probe for miss fills.
module writeback_buffer #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned BLOCK_ADDR_W = 8,
    parameter int unsigned BLOCK_SIZE   = 16,
    parameter int unsigned WORD_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    writeback_buffer_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned BLK_W = BLOCK_SIZE * WORD_W;
    localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(BLOCK_SIZE - 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [OFF_W-1:0]        word_idx_q, word_idx_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [BLOCK_ADDR_W-1:0] addr_q [DEPTH];
    logic [BLOCK_ADDR_W-1:0] addr_d [DEPTH];
    logic [BLK_W-1:0]        data_q [DEPTH];
    logic [BLK_W-1:0]        data_d [DEPTH];

    logic                    accept;
    logic                    retire;
    logic                    coal_hit;
    logic [PTR_W-1:0]        coal_idx;
    logic                    probe_sel;
    logic [PTR_W-1:0]        probe_idx;

    assign bus.evict_ready = (count_q != CNT_W'(DEPTH));
    assign accept          = bus.evict_valid && bus.evict_ready;
    assign retire          = (state_q == BURST) && bus.mem_wready && (word_idx_q == LAST_IDX);
    assign count           = count_q;
    assign empty           = (count_q == '0);

    // Queue update and drain sequencing
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        coal_hit   = 1'b0;
        coal_idx   = '0;

        // The head is frozen once its burst has started, so it cannot absorb a repeat eviction
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.evict_addr) &&
                !((state_q == BURST) && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end

        if (accept) begin
            if (coal_hit) begin
                data_d[coal_idx] = bus.evict_data;
            end else begin
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q]  = bus.evict_addr;
                data_d[tail_q]  = bus.evict_data;
                tail_d          = tail_q + PTR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d    = BURST;
                    word_idx_d = '0;
                end
            end
            BURST: begin
                if (bus.mem_wready) begin
                    word_idx_d = word_idx_q + OFF_W'(1);
                    if (word_idx_q == LAST_IDX) begin
                        valid_d[head_q] = 1'b0;
                        head_d          = head_q + PTR_W'(1);
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case ({accept && !coal_hit, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Memory write port decodes the head entry at the current word
    always_comb begin
        bus.mem_wvalid = 1'b0;
        bus.mem_waddr  = '0;
        bus.mem_wdata  = '0;
        bus.mem_wlast  = 1'b0;
        if (state_q == BURST) begin
            bus.mem_wvalid = 1'b1;
            bus.mem_waddr  = {addr_q[head_q], word_idx_q};
            bus.mem_wdata  = data_q[head_q][word_idx_q * WORD_W +: WORD_W];
            bus.mem_wlast  = (word_idx_q == LAST_IDX);
        end
    end

    // A non-head match is always newer than a matching head, so it wins
    always_comb begin
        probe_sel = 1'b0;
        probe_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.probe_addr) &&
                (!probe_sel || (PTR_W'(i) != head_q))) begin
                probe_sel = 1'b1;
                probe_idx = PTR_W'(i);
            end
        end
        bus.probe_hit  = probe_sel;
        bus.probe_data = probe_sel ? data_q[probe_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            valid_q    <= valid_d;
        end
    end

    // Payload storage is qualified by valid_q and needs no reset
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_writeback_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BAW   = 8;
    localparam int unsigned BS    = 16;
    localparam int unsigned WW    = 32;
    localparam int unsigned BLK_W = BS * WW;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [BAW-1:0]   addr;
        logic [BLK_W-1:0] data;
    } ent_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic        l;
    } wr_t;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] count;
    logic             empty;

    writeback_buffer_if #(.BLOCK_ADDR_W(BAW), .BLOCK_SIZE(BS), .WORD_W(WW)) bus ();

    writeback_buffer #(.DEPTH(DEPTH), .BLOCK_ADDR_W(BAW), .BLOCK_SIZE(BS), .WORD_W(WW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .empty (empty)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t mq[$];
    bit   m_burst = 0;
    int   m_widx  = 0;
    bit   m_live  = 0;
    wr_t  wlog[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] blk(input int base);
        logic [BLK_W-1:0] r;
        for (int i = 0; i < int'(BS); i++) r[i*WW +: WW] = 32'(base + i);
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] rnd_blk();
        logic [BLK_W-1:0] r;
        for (int i = 0; i < int'(BS); i++) r[i*WW +: WW] = $urandom;
        return r;
    endfunction

    // Reference model: FIFO of blocks, head drains one word per accepted write
    always @(posedge clk) begin : model
        bit acc;
        int cj;
        bit popped;
        if (rst) begin
            mq.delete();
            m_burst = 0;
            m_widx  = 0;
            m_live  = 1;
        end else if (m_live) begin
            acc = bus.evict_valid && (mq.size() < int'(DEPTH));
            cj  = -1;
            for (int j = 0; j < mq.size(); j++)
                if (mq[j].addr == bus.evict_addr && !(j == 0 && m_burst)) cj = j;
            popped = 0;
            if (m_burst) begin
                if (bus.mem_wready) begin
                    m_widx++;
                    if (m_widx == int'(BS)) begin
                        void'(mq.pop_front());
                        popped  = 1;
                        m_burst = 0;
                    end
                end
            end else if (mq.size() > 0) begin
                m_burst = 1;
                m_widx  = 0;
            end
            if (acc) begin
                if (cj >= 0) mq[popped ? cj - 1 : cj].data = bus.evict_data;
                else mq.push_back('{addr: bus.evict_addr, data: bus.evict_data});
            end
        end
    end

    // Per-cycle comparison against the model and memory-write capture
    always @(negedge clk) begin : cmp
        logic [BLK_W-1:0] pd;
        logic             ph;
        logic [11:0]      ea;
        logic [31:0]      ed;
        logic             el;
        if (bus.mem_wvalid && bus.mem_wready)
            wlog.push_back('{a: bus.mem_waddr, d: bus.mem_wdata, l: bus.mem_wlast});
        if (m_live) begin
            ph = 0;
            pd = '0;
            for (int j = mq.size() - 1; j >= 0; j--)
                if (!ph && mq[j].addr == bus.probe_addr) begin ph = 1; pd = mq[j].data; end
            ea = '0; ed = '0; el = 0;
            if (m_burst) begin
                ea = {mq[0].addr, 4'(m_widx)};
                ed = mq[0].data[m_widx*WW +: WW];
                el = (m_widx == int'(BS) - 1);
            end
            chk("count", count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("evict_ready", bus.evict_ready, mq.size() < int'(DEPTH));
            chk("mem_wvalid", bus.mem_wvalid, m_burst);
            chk("mem_waddr", bus.mem_waddr, ea);
            chk("mem_wdata", bus.mem_wdata, ed);
            chk("mem_wlast", bus.mem_wlast, el);
            chk("probe_hit", bus.probe_hit, ph);
            chk("probe_data", bus.probe_data, pd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic evict(input logic [BAW-1:0] a, input logic [BLK_W-1:0] d);
        int   b;
        logic r;
        b = 0;
        bus.evict_valid = 1'b1;
        bus.evict_addr  = a;
        bus.evict_data  = d;
        do begin
            @(negedge clk);
            r = bus.evict_ready;
            @(posedge clk);
            b++;
        end while (!r && b < 300);
        if (!r) chk("evict_timeout", 0, 1);
        #1 bus.evict_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int b;
        b = 0;
        do begin
            step(1);
            b++;
        end while (!(empty && !bus.mem_wvalid) && b < 600);
        chk("drain_timeout", empty, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        int b;
        int n;
        rst = 1'b1;
        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.probe_addr  = '0;
        bus.mem_wready  = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_evict_ready", bus.evict_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_mem_wvalid", bus.mem_wvalid, 0);
        chk("rst_probe_hit", bus.probe_hit, 0);

        // Single block drain with two-cycle latency
        bus.mem_wready = 1'b1;
        wlog.delete();
        evict(8'h12, blk(100));
        @(negedge clk);
        chk("lat_cycle1_wvalid", bus.mem_wvalid, 0);
        @(negedge clk);
        chk("lat_cycle2_wvalid", bus.mem_wvalid, 1);
        wait_empty();
        chk("single_len", wlog.size(), 16);
        if (wlog.size() == 16) begin
            chk("single_w0_addr", wlog[0].a, 12'h120);
            chk("single_w0_data", wlog[0].d, 100);
            chk("single_w15_addr", wlog[15].a, 12'h12F);
            chk("single_w15_data", wlog[15].d, 115);
            chk("single_w15_last", wlog[15].l, 1);
            nl = 0;
            foreach (wlog[k]) nl += int'(wlog[k].l);
            chk("single_wlast_count", nl, 1);
        end
        chk("single_empty", empty, 1);

        // Full: four accepted, fifth waits for the first retire
        bus.mem_wready = 1'b0;
        wlog.delete();
        for (int i = 0; i < 4; i++) evict(8'(8'h20 + i), blk(200 + 100 * i));
        step(3);
        chk("full_count", count, 4);
        chk("full_ready", bus.evict_ready, 0);
        bus.mem_wready = 1'b1;
        evict(8'h24, blk(600));
        wait_empty();
        chk("full_len", wlog.size(), 80);
        if (wlog.size() == 80) begin
            chk("full_first_addr", wlog[0].a, 12'h200);
            chk("full_fifth_addr", wlog[64].a, 12'h240);
            chk("full_fifth_data", wlog[64].d, 600);
        end

        // Coalesce into a queued, not-yet-draining entry
        bus.mem_wready = 1'b0;
        wlog.delete();
        evict(8'h01, blk(1000));
        evict(8'h05, blk(2000));
        evict(8'h07, blk(3000));
        evict(8'h05, blk(4000));
        chk("coal_count", count, 3);
        bus.mem_wready = 1'b1;
        wait_empty();
        chk("coal_len", wlog.size(), 48);
        if (wlog.size() == 48) begin
            chk("coal_b_addr", wlog[16].a, 12'h050);
            chk("coal_b_data0", wlog[16].d, 4000);
            chk("coal_b_data15", wlog[31].d, 4015);
            chk("coal_next_addr", wlog[32].a, 12'h070);
        end

        // Same address while its block is bursting allocates a second entry
        bus.mem_wready = 1'b0;
        wlog.delete();
        evict(8'h09, blk(5000));
        step(2);
        evict(8'h09, blk(6000));
        chk("burst_dup_count", count, 2);
        bus.mem_wready = 1'b1;
        wait_empty();
        chk("burst_dup_len", wlog.size(), 32);
        if (wlog.size() == 32) begin
            chk("burst_dup_first", wlog[0].d, 5000);
            chk("burst_dup_second_addr", wlog[16].a, 12'h090);
            chk("burst_dup_second_data", wlog[16].d, 6000);
        end

        // Probe hit, miss, and newest-of-two
        bus.mem_wready = 1'b0;
        evict(8'h33, blk(7000));
        bus.probe_addr = 8'h33;
        #1;
        chk("probe33_hit", bus.probe_hit, 1);
        chk("probe33_data", bus.probe_data, blk(7000));
        bus.probe_addr = 8'h34;
        #1;
        chk("probe34_hit", bus.probe_hit, 0);
        chk("probe34_data", bus.probe_data, 0);
        step(2);
        evict(8'h33, blk(8000));
        bus.probe_addr = 8'h33;
        #1;
        chk("probe_newest_hit", bus.probe_hit, 1);
        chk("probe_newest_data", bus.probe_data, blk(8000));
        bus.mem_wready = 1'b1;
        wait_empty();

        // Reset in the middle of a burst
        wlog.delete();
        evict(8'h44, blk(9000));
        b = 0;
        while (wlog.size() < 6 && b < 100) begin step(1); b++; end
        chk("rmb_started", wlog.size() >= 6, 1);
        rst = 1'b1;
        step(1);
        chk("rmb_wvalid", bus.mem_wvalid, 0);
        chk("rmb_count", count, 0);
        rst = 1'b0;
        n = wlog.size();
        step(25);
        chk("rmb_no_writes", wlog.size(), n);

        // Randomized traffic on a small address set to exercise coalescing and probes
        for (int c = 0; c < 3000; c++) begin
            bus.evict_valid = ($urandom_range(2) == 0);
            bus.evict_addr  = 8'(8'h30 + $urandom_range(5));
            bus.evict_data  = rnd_blk();
            bus.mem_wready  = ($urandom_range(3) != 0);
            bus.probe_addr  = 8'(8'h30 + $urandom_range(6));
            rst             = ($urandom_range(399) == 0);
            step(1);
        end
        bus.evict_valid = 1'b0;
        rst             = 1'b0;
        bus.mem_wready  = 1'b1;
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
